// File: rtl/stv_arb_pkg.sv
// Shared types and helpers for the stv round-robin arbiters.
// Holds the arbiter state enum and the index-width helper.
package stv_arb_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   // Width needed to index n items; never less than one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/stv_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after prio,
// scanning upward with wrap-around.
module stv_rr_pick
   import stv_arb_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IDXW = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] prio,
   output logic            any,
   output logic [IDXW-1:0] winner,
   output logic [NREQ-1:0] onehot
);

   logic [IDXW-1:0] idx;

   // Scan offsets from farthest to nearest so the nearest set request is written last.
   always_comb begin
      any    = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = IDXW'((int'(prio) + k) % NREQ);
         if (req[idx]) begin
            any    = 1'b1;
            winner = idx;
         end
      end
      onehot = any ? (NREQ'(1) << winner) : '0;
   end

endmodule

// File: rtl/stv_fifo_arb.sv
// Round-robin arbiter sharing one ready/valid sink among NREQ requesters,
// with optional packet locking or bounded bursts per grant.
module stv_fifo_arb
   import stv_arb_pkg::*;
#(
   parameter  type DTYPE    = logic [7:0],
   parameter  int  NREQ     = 4,
   parameter  int  LOCK     = 1,
   parameter  int  MAXBEATS = 0,
   localparam int  IDXW     = idx_w(NREQ)
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  DTYPE [NREQ-1:0]       req_data,
   input  logic [NREQ-1:0]       req_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output DTYPE                  out_data,
   output logic                  out_last,
   output logic [IDXW-1:0]       out_src,
   output logic                  locked
);

   // Handshake: a beat moves when out_valid && out_ready; req_ready mirrors
   // out_ready to the granted requester only, and an offered beat keeps its grant until taken.

   localparam int CW = idx_w(MAXBEATS + 1);

   arb_state_e      state, state_n;
   logic [IDXW-1:0] prio, prio_n;
   logic [IDXW-1:0] owner, owner_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [IDXW-1:0] src_q;
   logic            hold_q;
   logic            live;

   logic            pick_any;
   logic [IDXW-1:0] pick_idx;
   logic [NREQ-1:0] pick_onehot;
   logic [IDXW-1:0] g;
   logic [NREQ-1:0] grant_onehot;
   logic            have_grant;
   logic            accept;

   function automatic logic [IDXW-1:0] inc_idx(input logic [IDXW-1:0] i);
      return (i == IDXW'(NREQ - 1)) ? '0 : i + 1'b1;
   endfunction

   stv_rr_pick #(.NREQ(NREQ)) u_pick (
      .req    (req_valid),
      .prio   (prio),
      .any    (pick_any),
      .winner (pick_idx),
      .onehot (pick_onehot)
   );

   // live keeps the outputs quiet through reset and the first edge after it.
   always_comb begin
      g            = pick_idx;
      grant_onehot = pick_onehot;
      have_grant   = pick_any;
      if (state == ARB_LOCKED) begin
         g            = owner;
         grant_onehot = NREQ'(1) << owner;
         have_grant   = 1'b1;
      end else if (hold_q) begin
         g            = src_q;
         grant_onehot = NREQ'(1) << src_q;
         have_grant   = 1'b1;
      end
      if (!live) begin
         have_grant = 1'b0;
      end
   end

   assign out_valid = have_grant & req_valid[g];
   assign out_data  = req_data[g];
   assign out_last  = req_last[g];
   assign out_src   = have_grant ? g : src_q;
   assign req_ready = have_grant ? (grant_onehot & {NREQ{out_ready}}) : '0;
   assign accept    = out_valid & out_ready;
   assign locked    = (state == ARB_LOCKED);

   always_comb begin
      state_n = state;
      prio_n  = prio;
      owner_n = owner;
      cnt_n   = cnt;
      if (LOCK != 0) begin
         if (accept) begin
            if (out_last) begin
               state_n = ARB_IDLE;
               prio_n  = inc_idx(g);
            end else if (state == ARB_IDLE) begin
               state_n = ARB_LOCKED;
               owner_n = g;
            end
         end
      end else if (MAXBEATS == 0) begin
         if (accept) begin
            prio_n = inc_idx(g);
         end
      end else begin
         if (state == ARB_LOCKED && !req_valid[owner]) begin
            state_n = ARB_IDLE;
            prio_n  = inc_idx(owner);
            cnt_n   = '0;
         end else if (accept) begin
            if (cnt == CW'(MAXBEATS - 1)) begin
               state_n = ARB_IDLE;
               prio_n  = inc_idx(g);
               cnt_n   = '0;
            end else begin
               state_n = ARB_LOCKED;
               owner_n = g;
               cnt_n   = cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state  <= ARB_IDLE;
         prio   <= '0;
         owner  <= '0;
         cnt    <= '0;
         src_q  <= '0;
         hold_q <= 1'b0;
         live   <= 1'b0;
      end else begin
         state  <= state_n;
         prio   <= prio_n;
         owner  <= owner_n;
         cnt    <= cnt_n;
         src_q  <= out_src;
         hold_q <= out_valid & ~out_ready;
         live   <= 1'b1;
      end
   end

   a_params : assert property (@(posedge clk) (NREQ >= 2) && (LOCK == 0 || MAXBEATS == 0));
   a_onehot : assert property (@(posedge clk) disable iff (arst) $onehot0(req_ready));
   a_stable : assert property (@(posedge clk) disable iff (arst)
                               (out_valid && !out_ready) |=> (out_src == $past(out_src)));

endmodule

// File: doc/stv_fifo_arb.md
Name: stv_fifo_arb

Overview:
- N-input round-robin arbiter that shares one ready/valid sink, normally an stv_sync_fifo write port, between NREQ requesters.
- Optional packet locking keeps the grant on one requester until the beat marked "last", so packets are never interleaved in the shared FIFO.
- Sits in front of shared FIFOs in DMA/command paths.
- Reports the source index of each beat so downstream logic can demultiplex.

Parameters:
- DTYPE, logic[7:0], payload type (matches FIFO DTYPE).
- NREQ, 4, number of requesters; must be >= 2.
- LOCK, 1, 1 = hold grant until a beat with last=1 is accepted; 0 = re-arbitrate after every accepted beat.
- MAXBEATS, 0, LOCK=0 only: 0 = single beat per grant; >0 = keep grant for up to MAXBEATS consecutive accepted beats while the winner stays valid.
- IDXW, localparam $clog2(NREQ), source index width.

Ports:
- clk  input  1  clock; one clock domain.
- arst  input  1  reset; asynchronous, active-high.
- req_valid  input  NREQ  per-requester valid.
- req_ready  output  NREQ  per-requester ready.
- req_data  input  DTYPE[NREQ]  per-requester payload.
- req_last  input  NREQ  per-requester end-of-packet.
- out_valid  output  1  to sink (FIFO wvalid).
- out_ready  input  1  from sink (FIFO wready).
- out_data  output  DTYPE  muxed payload.
- out_last  output  1  muxed last.
- out_src  output  IDXW  index of the granted requester.
- locked  output  1  state is LOCKED (grant held).

Behaviour:
- Reset (arst=1, asynchronous):
  - state=IDLE, prio pointer=0, beat counter=0, locked=0.
  - out_valid=0 and req_ready=0 whenever all req_valid=0.
- FSM states:
  - IDLE: grant is chosen combinationally each cycle.
  - LOCKED: grant is the registered owner.
- Picking in IDLE:
  - Scan req_valid starting at the prio index, ascending with wrap (prio, prio+1, …, NREQ-1, 0, …).
  - The first set bit wins. There is zero-cycle latency: out_valid follows req_valid combinationally.
- Muxing:
  - out_valid = req_valid[g]; out_data/out_last = req_data[g]/req_last[g]; out_src = g.
  - req_ready = onehot(g) & {NREQ{out_ready}}; non-granted requesters always see ready=0.
  - With no winner in IDLE, out_src holds its last driven value; sinks must qualify it with out_valid.
- Accepted beat = out_valid && out_ready.
- LOCK=1:
  - Accepted beat with last=0 in IDLE: go to LOCKED, owner<=g.
  - In LOCKED, the grant stays on owner even if req_valid[owner] drops. In that case out_valid=0 and other requesters stay blocked.
  - Accepted beat with last=1 (from either state): go to IDLE, prio<=(g+1) mod NREQ.
- LOCK=0:
  - MAXBEATS=0: every accepted beat sets prio<=(g+1) mod NREQ. Stay IDLE; out_last is passed through only.
  - MAXBEATS>0, counter width $clog2(MAXBEATS+1):
    - Accepted beat increments the counter and enters LOCKED.
    - Release to IDLE (prio<=g+1, counter<=0) when counter reaches MAXBEATS, or when req_valid[owner]=0 in LOCKED. Release on dropped valid costs one idle cycle.
- Stalled sink: out_ready=0 holds grant, state and prio unchanged. Data stability is the requester's obligation under the ready/valid rules.
- Single requester active: it wins every cycle; no bubbles in IDLE.
- Wrap: prio=NREQ-1 with winner NREQ-1 sets next prio to 0. Use modulo arithmetic; no out-of-range index for non-power-of-2 NREQ.
- Reset mid-packet: lock is dropped immediately and prio returns to 0. Packet integrity across reset is the requesters' responsibility.
- Assertions (translate_off):
  - NREQ>=2.
  - MAXBEATS==0 when LOCK=1.
  - $onehot0(req_ready).
  - Grant stable while out_valid && !out_ready.

Decomposition:
- Package stv_arb_pkg holds the state enum (ARB_IDLE, ARB_LOCKED) and the index-width helper function.
- Sub-module stv_rr_pick: purely combinational rotate-priority picker.
  - Inputs: req vector, prio index. Outputs: any, winner index, onehot.
  - Reused by future arbiters.
- The top level holds the FSM, pointer, counter and muxing.

Test Plan:
- NREQ=4, LOCK=0, all four valid continuously, out_ready=1 -> out_src sequence 0,1,2,3,0,1… with one beat per cycle and no bubbles.
- LOCK=1, req0 sends a 3-beat packet (last on beat 3) while req1 is valid throughout -> out_src = 0,0,0 then 1; locked=1 for beats 2–3.
- LOCK=1, req2 drops valid mid-packet for 2 cycles while req3 is valid -> out_valid=0 for 2 cycles, req_ready[3]=0, then req2 resumes and completes before req3 is granted.
- out_ready=0 for 5 cycles with req1 and req2 valid -> out_src stays 1, prio unchanged, req_ready=0; after out_ready=1, order is 1 then 2.
- LOCK=0, MAXBEATS=2, req0 and req1 continuously valid -> out_src = 0,0,1,1,0,0.
- Assert arst while LOCKED on req3 -> locked=0 and out_valid=0 during reset; after release with all valid, first out_src=0.
